// File: rtl/multi_port_queue_pkg.sv
// multi_port_queue_pkg
//   Shared helpers for the multi-port in-order queue:
//     ptr_w / cnt_w  : pointer and occupancy widths derived from DEPTH
//     lane_cnt_t     : lane-count type wide enough for MAX_LANES lanes
//     popcount       : number of set bits in a lane mask
//   Optional statistics outputs on the queue are enabled by defining
//   MULTI_PORT_QUEUE_STATS_EN.
package multi_port_queue_pkg;

    localparam int unsigned MAX_LANES = 8;

    typedef logic [$clog2(MAX_LANES):0] lane_cnt_t;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Occupancy needs one extra bit so that a full queue (count==DEPTH)
    // is distinguishable from an empty one.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic lane_cnt_t popcount(input logic [MAX_LANES-1:0] v);
        lane_cnt_t c;
        c = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            c = c + lane_cnt_t'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/multi_port_queue_if.sv
// multi_port_queue_if
//   Handshake/status bundle of the multi-port queue.
//     enqueue_en/enqueue_data   : per-lane write request and data (producer)
//     enqueue_ready             : room for a full set of write lanes
//     dequeue_en                : per-lane pop request (consumer)
//     dequeue_valid/dequeue_data: oldest READ_PORTS entries
//     count/free_cnt/empty/full : occupancy status
//   master = producer/consumer side, slave = queue side.
interface multi_port_queue_if
    import multi_port_queue_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int WRITE_PORTS = 2,
    parameter int READ_PORTS  = 2
);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [WRITE_PORTS-1:0]                 enqueue_en;
    logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] enqueue_data;
    logic                                   enqueue_ready;
    logic [READ_PORTS-1:0]                  dequeue_en;
    logic [READ_PORTS-1:0]                  dequeue_valid;
    logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  dequeue_data;
    logic [CNT_W-1:0]                       count;
    logic [CNT_W-1:0]                       free_cnt;
    logic                                   empty;
    logic                                   full;

    modport master (
        output enqueue_en, enqueue_data, dequeue_en,
        input  enqueue_ready, dequeue_valid, dequeue_data,
               count, free_cnt, empty, full
    );

    modport slave (
        input  enqueue_en, enqueue_data, dequeue_en,
        output enqueue_ready, dequeue_valid, dequeue_data,
               count, free_cnt, empty, full
    );

endinterface

// File: rtl/multi_port_queue_lane_compact.sv
// lane_compact
//   Purely combinational write-lane compaction.
//   Ports:
//     lane_mask   in  WRITE_PORTS          accepted write lanes
//     lane_offset out WRITE_PORTS x OFF_W  slot offset of each lane from tail
//                                          (number of set lanes below it)
//     lane_total  out TOT_W                number of set lanes
//   Offsets of unset lanes are don't-care to the caller.
module lane_compact
    import multi_port_queue_pkg::*;
#(
    parameter int WRITE_PORTS = 2,
    parameter int OFF_W       = 4,
    parameter int TOT_W       = 5
) (
    input  logic [WRITE_PORTS-1:0]            lane_mask,
    output logic [WRITE_PORTS-1:0][OFF_W-1:0] lane_offset,
    output logic [TOT_W-1:0]                  lane_total
);

    logic [OFF_W-1:0] acc;

    always_comb begin
        acc         = '0;
        lane_offset = '0;
        for (int i = 0; i < WRITE_PORTS; i++) begin
            lane_offset[i] = acc;
            acc            = acc + OFF_W'(lane_mask[i]);
        end
        lane_total = TOT_W'(popcount(MAX_LANES'(lane_mask)));
    end

endmodule

// File: rtl/multi_port_queue.sv
// multi_port_queue
//   N-write / M-read in-order circular queue. Sparse write lanes are
//   compacted in ascending lane order; the oldest READ_PORTS entries are
//   presented with per-lane valid.
//   Ports:
//     clk, rst_n (async active-low), flush (sync clear)
//     q_if  : multi_port_queue_if.slave (enqueue/dequeue handshake, status)
//   Optional (MULTI_PORT_QUEUE_STATS_EN defined):
//     overflow_err  sticky: write attempted while not ready
//     underflow_err sticky: pop requested on an invalid lane
//     max_count     high-water mark of count
//   Statistics are cleared only by rst_n.
module multi_port_queue
    import multi_port_queue_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int WRITE_PORTS = 2,
    parameter int READ_PORTS  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    multi_port_queue_if.slave         q_if
`ifdef MULTI_PORT_QUEUE_STATS_EN
    ,
    output logic                      overflow_err,
    output logic                      underflow_err,
    output logic [cnt_w(DEPTH)-1:0]   max_count
`endif
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Distributed storage; contents are meaningless outside [head, head+count).
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [CNT_W-1:0]                   free_cnt;
    logic                               enq_ready;
    logic [WRITE_PORTS-1:0]             enq_mask;
    logic [WRITE_PORTS-1:0][PTR_W-1:0]  lane_offset;
    logic [CNT_W-1:0]                   n_enq;
    logic [READ_PORTS-1:0]              deq_valid;
    logic [CNT_W-1:0]                   n_deq;
    logic                               deq_run;

    lane_compact #(
        .WRITE_PORTS (WRITE_PORTS),
        .OFF_W       (PTR_W),
        .TOT_W       (CNT_W)
    ) u_lane_compact (
        .lane_mask   (enq_mask),
        .lane_offset (lane_offset),
        .lane_total  (n_enq)
    );

    // Status and read view, all from registered state.
    always_comb begin
        free_cnt  = CNT_W'(DEPTH) - count_q;
        // Ready is judged on the pre-dequeue count, so a full queue cannot
        // be refilled in the same cycle it is drained.
        enq_ready = (free_cnt >= CNT_W'(WRITE_PORTS));
        // Gate the whole mask: a write while not ready is dropped atomically.
        enq_mask  = q_if.enqueue_en & {WRITE_PORTS{enq_ready}};

        q_if.dequeue_data = '0;
        for (int i = 0; i < READ_PORTS; i++) begin
            deq_valid[i] = (CNT_W'(i) < count_q);
            if (deq_valid[i]) begin
                q_if.dequeue_data[i] = mem_q[head_q + PTR_W'(i)];
            end
        end

        // Only the leading run of accepted lanes from lane 0 pops; anything
        // after the first gap is ignored to keep retirement in order.
        deq_run = 1'b1;
        n_deq   = '0;
        for (int i = 0; i < READ_PORTS; i++) begin
            deq_run = deq_run & q_if.dequeue_en[i] & deq_valid[i];
            n_deq   = n_deq + CNT_W'(deq_run);
        end

        q_if.dequeue_valid = deq_valid;
        q_if.enqueue_ready = enq_ready;
        q_if.count         = count_q;
        q_if.free_cnt      = free_cnt;
        q_if.empty         = (count_q == '0);
        q_if.full          = (count_q == CNT_W'(DEPTH));
    end

    // Next-state pointers; flush wins over any same-cycle traffic.
    always_comb begin
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + n_deq[PTR_W-1:0];
            tail_d  = tail_q + n_enq[PTR_W-1:0];
            count_d = count_q + n_enq - n_deq;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage writes: lane i lands at tail + (set lanes below i).
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int i = 0; i < WRITE_PORTS; i++) begin
                if (enq_mask[i]) begin
                    mem_q[tail_q + lane_offset[i]] <= q_if.enqueue_data[i];
                end
            end
        end
    end

`ifdef MULTI_PORT_QUEUE_STATS_EN
    logic             overflow_err_q, overflow_err_d;
    logic             underflow_err_q, underflow_err_d;
    logic [CNT_W-1:0] max_count_q, max_count_d;

    always_comb begin
        overflow_err_d  = overflow_err_q | ((|q_if.enqueue_en) & ~enq_ready);
        underflow_err_d = underflow_err_q | (|(q_if.dequeue_en & ~deq_valid));
        // Track the next count so the mark moves in step with count itself.
        max_count_d     = (count_d > max_count_q) ? count_d : max_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_err_q  <= 1'b0;
            underflow_err_q <= 1'b0;
            max_count_q     <= '0;
        end else begin
            overflow_err_q  <= overflow_err_d;
            underflow_err_q <= underflow_err_d;
            max_count_q     <= max_count_d;
        end
    end

    assign overflow_err  = overflow_err_q;
    assign underflow_err = underflow_err_q;
    assign max_count     = max_count_q;
`endif

endmodule
